pipeline_ctrl: RTL and testbench
================================

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 Parameter DIV_CYCLES, default 32, number of BUSY cycles of the iterative divider (legal range 1..63).
REQ-002 clk  input  1  rising-edge clock; the block SHALL use this single clock.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 ID_rs, ID_rt  input  5 each  source registers of the instruction in ID.
REQ-005 EXE_Dst  input  5  destination register of the instruction in EXE.
REQ-006 EXE_ReadMem  input  1  the instruction in EXE is a load (LoadType.ReadMem).
REQ-007 EXE_DivStart  input  1  the instruction in EXE is DIV/DIVU.
REQ-008 ID_BranchTaken  input  1  a branch or jump in ID redirects the PC.
REQ-009 MEM_ExceptValid  input  1  an exception or ERET is committed in MEM.
REQ-010 IF_PCWr, IF_IDWr, IDEXE_Wr  output  1 each  write enables for PC, IF/ID and ID/EXE.
REQ-011 IFID_Flush, IDEXE_Flush, EXEMEM_Flush  output  1 each  bubble-insert controls.
REQ-012 Div_Busy, Div_Done  output  1 each  divider running; result valid this cycle.

Function
REQ-013 FSM states: IDLE, BUSY, DONE; 6-bit down-counter cnt.
REQ-014 IDLE with EXE_DivStart=1 -> BUSY, cnt<=DIV_CYCLES-1; otherwise stay in IDLE.
REQ-015 BUSY with cnt!=0 -> cnt<=cnt-1; BUSY with cnt==0 -> DONE.
REQ-016 DONE -> IDLE unconditionally; EXE_DivStart SHALL be ignored in DONE, since the same DIV is still in EXE.
REQ-017 Divide stall condition: (IDLE & EXE_DivStart) | BUSY.
REQ-018 While the divide stall holds: IF_PCWr=IF_IDWr=IDEXE_Wr=0, EXEMEM_Flush=1, Div_Busy=1 (Div_Busy only in BUSY); the total freeze is DIV_CYCLES+1 cycles.
REQ-019 DONE: Div_Done=1, all write enables=1, EXEMEM_Flush=0, so the DIV advances to MEM.
REQ-020 Load-use condition: EXE_ReadMem & EXE_Dst!=0 & (EXE_Dst==ID_rs | EXE_Dst==ID_rt).
REQ-021 Load-use response: IF_PCWr=IF_IDWr=0, IDEXE_Flush=1 for each cycle the condition holds.
REQ-022 ID_BranchTaken with no higher-priority event: IFID_Flush=1 and IF_PCWr=1.
REQ-023 MEM_ExceptValid: IFID_Flush=IDEXE_Flush=EXEMEM_Flush=1 and IF_PCWr=IF_IDWr=IDEXE_Wr=1.
REQ-024 MEM_ExceptValid in BUSY or DONE SHALL abort the divide: next state IDLE, cnt<=0, Div_Done=0.
REQ-025 Priority: exception > divide stall > load-use > branch. A lower event is suppressed entirely while a higher one is active.
REQ-026 Default (no event): all write enables=1, all flushes=0, Div_Busy=Div_Done=0.
REQ-027 All outputs SHALL be combinational from state, cnt and inputs, with no extra latency.

Reset
REQ-028 rst=0 SHALL force state=IDLE and cnt=0 asynchronously, including mid-BUSY.
REQ-029 While rst=0 and after release, with idle inputs, outputs SHALL equal the REQ-026 defaults.

Structure
REQ-030 The FSM state enum and the DIV_CYCLES default SHALL live in the shared CPU defines package.
REQ-031 Single module; there is no sub-module.

Verification
REQ-032 EXE_ReadMem=1, EXE_Dst=5, ID_rs=5 for 1 cycle -> IF_PCWr=0, IF_IDWr=0, IDEXE_Flush=1 in that cycle; defaults the next cycle.
REQ-033 Same as REQ-032 but EXE_Dst=0 -> no stall.
REQ-034 DIV_CYCLES=4, EXE_DivStart held -> stall for 5 cycles, Div_Busy=1 for 4 of them, then Div_Done=1 for 1 cycle, then IDLE.
REQ-035 DIV_CYCLES=4, MEM_ExceptValid at BUSY cnt=2 -> all three flushes=1 that cycle; IDLE and Div_Busy=0 next cycle.
REQ-036 rst=0 asserted mid-BUSY -> IDLE immediately; after release, with EXE_DivStart=0, defaults.
REQ-037 Load-use plus ID_BranchTaken in the same cycle -> load-use stall only (IFID_Flush=0); branch honored the following cycle.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared CPU pipeline-control definitions: divider FSM states and the
// default iterative-divide latency.
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_t;

    localparam int DIV_CYCLES_DEF = 32;
    localparam int CNT_W          = 6;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Hazard/stall control bundle between the pipeline stages and pipeline_ctrl.
interface pipeline_ctrl_if;

    logic [4:0] ID_rs;
    logic [4:0] ID_rt;
    logic [4:0] EXE_Dst;
    logic       EXE_ReadMem;
    logic       EXE_DivStart;
    logic       ID_BranchTaken;
    logic       MEM_ExceptValid;

    logic       IF_PCWr;
    logic       IF_IDWr;
    logic       IDEXE_Wr;
    logic       IFID_Flush;
    logic       IDEXE_Flush;
    logic       EXEMEM_Flush;
    logic       Div_Busy;
    logic       Div_Done;

    modport master (
        output ID_rs, ID_rt, EXE_Dst, EXE_ReadMem, EXE_DivStart,
               ID_BranchTaken, MEM_ExceptValid,
        input  IF_PCWr, IF_IDWr, IDEXE_Wr, IFID_Flush, IDEXE_Flush,
               EXEMEM_Flush, Div_Busy, Div_Done
    );

    modport slave (
        input  ID_rs, ID_rt, EXE_Dst, EXE_ReadMem, EXE_DivStart,
               ID_BranchTaken, MEM_ExceptValid,
        output IF_PCWr, IF_IDWr, IDEXE_Wr, IFID_Flush, IDEXE_Flush,
               EXEMEM_Flush, Div_Busy, Div_Done
    );

endinterface

// File: rtl/pipeline_ctrl.sv
// Pipeline hazard controller: exception flush, iterative-divide freeze,
// load-use stall and branch flush, resolved by fixed priority.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
    input logic           clk,
    input logic           rst,
    pipeline_ctrl_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(DIV_CYCLES - 1);

    div_state_t       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             load_use;
    logic             div_stall;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    assign load_use  = bus.EXE_ReadMem && (bus.EXE_Dst != 5'd0) &&
                       ((bus.EXE_Dst == bus.ID_rs) || (bus.EXE_Dst == bus.ID_rt));
    assign div_stall = ((state == IDLE) && bus.EXE_DivStart) || (state == BUSY);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        unique case (state)
            // An exception flushes the DIV out of EXE, so it must not start.
            IDLE: if (bus.EXE_DivStart && !bus.MEM_ExceptValid) begin
                state_nxt = BUSY;
                cnt_nxt   = CNT_INIT;
            end
            BUSY: begin
                if (bus.MEM_ExceptValid) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt != '0) begin
                    cnt_nxt   = cnt - CNT_W'(1);
                end else begin
                    state_nxt = DONE;
                end
            end
            // The finished DIV is still in EXE here; its DivStart is stale.
            DONE: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        bus.IF_PCWr      = 1'b1;
        bus.IF_IDWr      = 1'b1;
        bus.IDEXE_Wr     = 1'b1;
        bus.IFID_Flush   = 1'b0;
        bus.IDEXE_Flush  = 1'b0;
        bus.EXEMEM_Flush = 1'b0;
        bus.Div_Busy     = 1'b0;
        bus.Div_Done     = 1'b0;
        if (bus.MEM_ExceptValid) begin
            bus.IFID_Flush   = 1'b1;
            bus.IDEXE_Flush  = 1'b1;
            bus.EXEMEM_Flush = 1'b1;
        end else if (div_stall) begin
            bus.IF_PCWr      = 1'b0;
            bus.IF_IDWr      = 1'b0;
            bus.IDEXE_Wr     = 1'b0;
            bus.EXEMEM_Flush = 1'b1;
            bus.Div_Busy     = (state == BUSY);
        end else begin
            bus.Div_Done = (state == DONE);
            if (load_use) begin
                bus.IF_PCWr     = 1'b0;
                bus.IF_IDWr     = 1'b0;
                bus.IDEXE_Flush = 1'b1;
            end else if (bus.ID_BranchTaken) begin
                bus.IFID_Flush = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: combinational hazard table plus divide,
// exception-abort and reset sequences, with DIV_CYCLES=4.
module tb_pipeline_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    pipeline_ctrl_if bus_if ();

    pipeline_ctrl #(.DIV_CYCLES(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    // {PCWr, IDWr, IDEXEWr, IFIDFl, IDEXEFl, EXEMEMFl, Busy, Done}
    localparam logic [7:0] O_DEF  = 8'b111_000_00;
    localparam logic [7:0] O_LU   = 8'b001_010_00;
    localparam logic [7:0] O_BR   = 8'b111_100_00;
    localparam logic [7:0] O_EXC  = 8'b111_111_00;
    localparam logic [7:0] O_DST  = 8'b000_001_00;
    localparam logic [7:0] O_BUSY = 8'b000_001_10;
    localparam logic [7:0] O_DONE = 8'b111_000_01;
    localparam logic [7:0] M_ALL  = 8'hFF;
    localparam logic [7:0] M_NOBSY = 8'b111_111_01;

    wire [7:0] outs = {bus_if.IF_PCWr, bus_if.IF_IDWr, bus_if.IDEXE_Wr,
                       bus_if.IFID_Flush, bus_if.IDEXE_Flush, bus_if.EXEMEM_Flush,
                       bus_if.Div_Busy, bus_if.Div_Done};

    typedef struct {
        string      name;
        logic [4:0] rs, rt, dst;
        logic       rdm, br, exc;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[13];

    function automatic vec_t mk(string n, logic [4:0] rs, logic [4:0] rt, logic [4:0] dst,
                                logic rdm, logic br, logic exc, logic [7:0] exp);
        vec_t v;
        v.name = n; v.rs = rs; v.rt = rt; v.dst = dst;
        v.rdm = rdm; v.br = br; v.exc = exc; v.exp = exp;
        return v;
    endfunction

    task automatic drive(logic [4:0] rs, logic [4:0] rt, logic [4:0] dst,
                         logic rdm, logic div, logic br, logic exc);
        bus_if.ID_rs = rs; bus_if.ID_rt = rt; bus_if.EXE_Dst = dst;
        bus_if.EXE_ReadMem = rdm; bus_if.EXE_DivStart = div;
        bus_if.ID_BranchTaken = br; bus_if.MEM_ExceptValid = exc;
    endtask

    task automatic check_now(string name, logic [7:0] exp, logic [7:0] mask);
        checks++;
        if ((outs & mask) !== (exp & mask)) begin
            errors++;
            $display("FAIL %s: got %b expected %b (mask %b)", name, outs, exp, mask);
        end
    endtask

    // Check at the falling edge, then advance to just after the next rising edge.
    task automatic cycle_check(string name, logic [7:0] exp, logic [7:0] mask);
        @(negedge clk);
        check_now(name, exp, mask);
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        #2;
        check_now("reset_held", O_DEF, M_ALL);
        @(posedge clk); #1;
        rst = 1'b1;
        cycle_check("after_release", O_DEF, M_ALL);

        vecs[0]  = mk("idle_default",   5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, O_DEF);
        vecs[1]  = mk("loaduse_rs",     5'd5, 5'd9, 5'd5, 1'b1, 1'b0, 1'b0, O_LU);
        vecs[2]  = mk("loaduse_next",   5'd5, 5'd9, 5'd5, 1'b0, 1'b0, 1'b0, O_DEF);
        vecs[3]  = mk("loaduse_dst0",   5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, O_DEF);
        vecs[4]  = mk("loaduse_rt",     5'd4, 5'd17, 5'd17, 1'b1, 1'b0, 1'b0, O_LU);
        vecs[5]  = mk("load_nomatch",   5'd5, 5'd6, 5'd7, 1'b1, 1'b0, 1'b0, O_DEF);
        vecs[6]  = mk("branch",         5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b0, O_BR);
        vecs[7]  = mk("lu_over_branch", 5'd31, 5'd2, 5'd31, 1'b1, 1'b1, 1'b0, O_LU);
        vecs[8]  = mk("branch_after_lu",5'd31, 5'd2, 5'd30, 1'b1, 1'b1, 1'b0, O_BR);
        vecs[9]  = mk("exception",      5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, O_EXC);
        vecs[10] = mk("exc_over_all",   5'd8, 5'd8, 5'd8, 1'b1, 1'b1, 1'b1, O_EXC);
        vecs[11] = mk("nonload_match",  5'd8, 5'd8, 5'd8, 1'b0, 1'b1, 1'b0, O_BR);
        vecs[12] = mk("final_default",  5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, O_DEF);

        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].rs, vecs[i].rt, vecs[i].dst, vecs[i].rdm, 1'b0,
                  vecs[i].br, vecs[i].exc);
            cycle_check(vecs[i].name, vecs[i].exp, M_ALL);
        end

        // Full divide, DivStart held through DONE (must be ignored there).
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle_check("div_start", O_DST, M_ALL);
        for (int i = 0; i < 4; i++) cycle_check($sformatf("div_busy%0d", i), O_BUSY, M_ALL);
        cycle_check("div_done", O_DONE, M_ALL);
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle_check("div_idle", O_DEF, M_ALL);

        // Exception at BUSY cnt=2 aborts the divide.
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle_check("abort_start", O_DST, M_ALL);
        cycle_check("abort_busy3", O_BUSY, M_ALL);
        bus_if.MEM_ExceptValid = 1'b1;
        cycle_check("abort_exc", O_EXC, M_NOBSY);
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle_check("abort_idle", O_DEF, M_ALL);

        // Exception in DONE suppresses Div_Done.
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle_check("dexc_start", O_DST, M_ALL);
        for (int i = 0; i < 4; i++) cycle_check($sformatf("dexc_busy%0d", i), O_BUSY, M_ALL);
        bus_if.MEM_ExceptValid = 1'b1;
        cycle_check("dexc_done_exc", O_EXC, M_NOBSY);
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle_check("dexc_idle", O_DEF, M_ALL);

        // Asynchronous reset mid-BUSY.
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle_check("rst_start", O_DST, M_ALL);
        cycle_check("rst_busy", O_BUSY, M_ALL);
        bus_if.EXE_DivStart = 1'b0;
        #1;
        check_now("rst_prebusy", O_BUSY, M_ALL);
        rst = 1'b0;
        #1;
        check_now("rst_async", O_DEF, M_ALL);
        @(posedge clk); #1;
        rst = 1'b1;
        cycle_check("rst_release0", O_DEF, M_ALL);
        cycle_check("rst_release1", O_DEF, M_ALL);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
